id_ex_stage: RTL

Pipeline register between instruction decode and the execute-stage ALU. It captures decoded operands and control for one instruction per cycle and presents them to the ALU (ALUControl, A, B, C) and to the downstream EX/MEM stage. It detects load-use hazards itself and inserts a one-cycle bubble, and it honours external stall and flush from the hazard/branch logic. A saturating bubble counter supports performance debug.

---
 rtl/id_ex_stage.sv | 125 ++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures one decoded instruction per cycle for the ALU and EX/MEM,
// inserts a one-cycle bubble on a load-use hazard, and honours external stall and flush.
module id_ex_stage #(
   parameter int BUBBLE_CNT_W = 16
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    ID_Valid,
   input  logic [5:0]              ID_ALUControl,
   input  logic [31:0]             ID_ReadData1,
   input  logic [31:0]             ID_ReadData2,
   input  logic [31:0]             ID_Imm,
   input  logic [4:0]              ID_Rs,
   input  logic [4:0]              ID_Rt,
   input  logic [4:0]              ID_Rd,
   input  logic                    ID_UsesRt,
   input  logic                    ID_RegWrite,
   input  logic                    ID_MemRead,
   input  logic                    ID_MemWrite,
   input  logic                    ID_MemToReg,
   input  logic                    ID_RegDst,
   input  logic                    ID_ALUSrc,
   input  logic [31:0]             ID_PCPlus4,
   input  logic                    Stall,
   input  logic                    Flush,
   output logic                    EX_Valid,
   output logic [5:0]              EX_ALUControl,
   output logic [31:0]             EX_ReadData1,
   output logic [31:0]             EX_ReadData2,
   output logic [31:0]             EX_Imm,
   output logic [4:0]              EX_Rs,
   output logic [4:0]              EX_Rt,
   output logic [4:0]              EX_Rd,
   output logic                    EX_UsesRt,
   output logic                    EX_RegWrite,
   output logic                    EX_MemRead,
   output logic                    EX_MemWrite,
   output logic                    EX_MemToReg,
   output logic                    EX_RegDst,
   output logic                    EX_ALUSrc,
   output logic [31:0]             EX_PCPlus4,
   output logic                    HazardStall,
   output logic [BUBBLE_CNT_W-1:0] BubbleCount
);

   localparam logic [BUBBLE_CNT_W-1:0] CNT_ONE = {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};

   logic load_bubble;
   logic load_id;
   logic count_bubble;

   // A load in EX whose destination is a source of the instruction in ID cannot forward in time.
   assign HazardStall = EX_Valid & EX_MemRead & ID_Valid & (EX_Rt != 5'd0) &
                        ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt)));

   // Priority: Flush > Stall > HazardStall > normal load. Upstream must hold ID while HazardStall=1.
   assign load_bubble  = Flush | (~Stall & HazardStall);
   assign load_id      = ~Flush & ~Stall & ~HazardStall;
   assign count_bubble = ~Flush & ~Stall & HazardStall & (BubbleCount != '1);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         EX_Valid      <= 1'b0;
         EX_ALUControl <= '0;
         EX_ReadData1  <= '0;
         EX_ReadData2  <= '0;
         EX_Imm        <= '0;
         EX_Rs         <= '0;
         EX_Rt         <= '0;
         EX_Rd         <= '0;
         EX_UsesRt     <= 1'b0;
         EX_RegWrite   <= 1'b0;
         EX_MemRead    <= 1'b0;
         EX_MemWrite   <= 1'b0;
         EX_MemToReg   <= 1'b0;
         EX_RegDst     <= 1'b0;
         EX_ALUSrc     <= 1'b0;
         EX_PCPlus4    <= '0;
      end else if (load_bubble) begin
         EX_Valid      <= 1'b0;
         EX_ALUControl <= '0;
         EX_ReadData1  <= '0;
         EX_ReadData2  <= '0;
         EX_Imm        <= '0;
         EX_Rs         <= '0;
         EX_Rt         <= '0;
         EX_Rd         <= '0;
         EX_UsesRt     <= 1'b0;
         EX_RegWrite   <= 1'b0;
         EX_MemRead    <= 1'b0;
         EX_MemWrite   <= 1'b0;
         EX_MemToReg   <= 1'b0;
         EX_RegDst     <= 1'b0;
         EX_ALUSrc     <= 1'b0;
         EX_PCPlus4    <= '0;
      end else if (load_id) begin
         EX_Valid      <= ID_Valid;
         EX_ALUControl <= ID_ALUControl;
         EX_ReadData1  <= ID_ReadData1;
         EX_ReadData2  <= ID_ReadData2;
         EX_Imm        <= ID_Imm;
         EX_Rs         <= ID_Rs;
         EX_Rt         <= ID_Rt;
         EX_Rd         <= ID_Rd;
         EX_UsesRt     <= ID_UsesRt;
         EX_RegWrite   <= ID_RegWrite;
         EX_MemRead    <= ID_MemRead;
         EX_MemWrite   <= ID_MemWrite;
         EX_MemToReg   <= ID_MemToReg;
         EX_RegDst     <= ID_RegDst;
         EX_ALUSrc     <= ID_ALUSrc;
         EX_PCPlus4    <= ID_PCPlus4;
      end
   end

   // Counts only hazard bubbles; flush bubbles are squashes, not load-use cost.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         BubbleCount <= '0;
      end else if (count_bubble) begin
         BubbleCount <= BubbleCount + CNT_ONE;
      end
   end

endmodule
